// File: rtl/led_scan_rom_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic [7:0] SSEG_OFF = 8'hFF;

  // Width of the slot counter for a given divider.
  function automatic int unsigned cnt_width(input int unsigned div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/led_scan_rom_ctrl_if.sv
// Pattern-ROM read bus: registered address out, data back one cycle later.
interface led_scan_rom_ctrl_if;
  logic [3:0] rom_addr;
  logic [6:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/led_scan_rom_ctrl_slot_timer.sv
// Digit-slot counter: counts 0..TICK_DIV-1, flags the prefetch cycle.
module disp_slot_timer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic pre_stb_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at the end of the slot or when the scanner closes the slot.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_W'(TICK_DIV - 1))) begin
      cnt_d = '0;
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pre_stb_c = (cnt_q == CNT_W'(TICK_DIV - 3));

endmodule

// File: rtl/led_scan_rom_ctrl.sv
// Seven-segment scan controller with ROM prefetch and single-edge output swap.
// Optional leading-zero suppression: define DISP_LZ_BLANK_EN.
module led_scan_rom_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*N_DIG-1:0]   hex_in,
  input  logic [N_DIG-1:0]     dp_in,
  input  logic [N_DIG-1:0]     blank_in,
  led_scan_rom_ctrl_if.master  rom,
  output logic [N_DIG-1:0]     an_n,
  output logic [7:0]           sseg_n
);

  localparam int unsigned IDX_W = $clog2(N_DIG);
  localparam int unsigned CNT_W = cnt_width(TICK_DIV);

  localparam logic [1:0] SCAN  = 2'(ST_SCAN);
  localparam logic [1:0] FETCH = 2'(ST_FETCH);
  localparam logic [1:0] LATCH = 2'(ST_LATCH);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_c;
  logic [3:0]       rom_addr_q, rom_addr_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [7:0]       sseg_q, sseg_d;
  logic [N_DIG-1:0] blank_eff_c;
  logic             pre_stb_c;

  disp_slot_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q == LATCH),
    .pre_stb_c (pre_stb_c)
  );

  // Next digit index with wrap to 0.
  always_comb begin
    nxt_c = idx_q + IDX_W'(1);
    if (idx_q == IDX_W'(N_DIG - 1)) begin
      nxt_c = '0;
    end
  end

`ifdef DISP_LZ_BLANK_EN
  logic [N_DIG-1:0] lz_c;
  logic             all_zero;

  // A digit is a leading zero if it and every digit above it are zero.
  always_comb begin
    lz_c     = '0;
    all_zero = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      all_zero = all_zero & (hex_in[4*i +: 4] == 4'h0);
      lz_c[i]  = all_zero;
    end
    blank_eff_c = blank_in | lz_c;
  end
`else
  // Blanking comes from the register block only.
  always_comb begin
    blank_eff_c = blank_in;
  end
`endif

  // Scan sequencing: prefetch next pattern, then swap anode and segments together.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    an_d       = an_q;
    sseg_d     = sseg_q;
    case (state_q)
      SCAN: begin
        if (pre_stb_c) begin
          rom_addr_d = hex_in[{nxt_c, 2'b00} +: 4];
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        sseg_d  = {~dp_in[nxt_c], rom.rom_data};
        an_d    = blank_eff_c[nxt_c] ? '1 : ~(N_DIG'(1) << nxt_c);
        idx_d   = nxt_c;
        state_d = SCAN;
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      idx_q      <= '0;
      rom_addr_q <= 4'h0;
      an_q       <= '1;
      sseg_q     <= SSEG_OFF;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign an_n         = an_q;
  assign sseg_n       = sseg_q;

endmodule

// File: tb/tb_led_scan_rom_ctrl.sv
// Directed bench for led_scan_rom_ctrl (N_DIG=4, TICK_DIV=8) with a hex-table ROM model.
module tb_led_scan_rom_ctrl;

  localparam int unsigned N_DIG    = 4;
  localparam int unsigned TICK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] hex_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  an_n;
  logic [7:0]  sseg_n;

  int n_chk  = 0;
  int n_pass = 0;

  led_scan_rom_ctrl_if rom_if ();

  led_scan_rom_ctrl #(
    .N_DIG    (N_DIG),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hex_in   (hex_in),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .rom      (rom_if.master),
    .an_n     (an_n),
    .sseg_n   (sseg_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_tbl(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Synchronous pattern ROM, one cycle read latency.
  always @(posedge clk) rom_if.rom_data <= seg_tbl(rom_if.rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After return, the next posedge ends cycle 0 after reset release.
  task automatic reset_dut();
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] an_e, input logic [7:0] sseg_e);
    chk({tag, "_an"}, 32'(an_n), 32'(an_e));
    chk({tag, "_sseg"}, 32'(sseg_n), 32'(sseg_e));
  endtask

  logic [3:0] exp_an [4];
  logic [7:0] exp_sg [4];

  initial begin
    // Reset state
    hex_in = 16'h3210;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an_n), 32'h0000000F);
    chk("rst_sseg", 32'(sseg_n), 32'h000000FF);
    chk("rst_addr", 32'(rom_if.rom_addr), 32'h0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(7);
    chk("dark_first_slot", 32'(an_n), 32'h0000000F);
    step(1);
    chk_slot("first_lit", 4'b1101, 8'hF9);

    // Scan order and hold
    exp_an = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};
    exp_sg = '{8'hA4, 8'hB0, 8'hC0, 8'hF9};
    for (int s = 0; s < 4; s++) begin
      step(7);
      chk("hold_an", 32'(an_n), (s == 0) ? 32'b1101 : 32'(exp_an[s-1]));
      step(1);
      chk_slot("scan", exp_an[s], exp_sg[s]);
    end

    // ROM sequencing
    hex_in = 16'hFA10;
    reset_dut();
    step(5);
    chk("addr_c5", 32'(rom_if.rom_addr), 32'h0);
    step(1);
    chk("addr_d1", 32'(rom_if.rom_addr), 32'h1);
    step(1);
    chk("data_d1", 32'(rom_if.rom_data), 32'h79);
    step(1);
    chk_slot("rom_d1", 4'b1101, 8'hF9);
    step(5);
    chk("addr_hold", 32'(rom_if.rom_addr), 32'h1);
    step(1);
    chk("addr_d2", 32'(rom_if.rom_addr), 32'hA);
    step(1);
    chk("data_A", 32'(rom_if.rom_data), 32'h08);
    step(1);
    chk_slot("rom_d2", 4'b1011, 8'h88);
    step(6);
    chk("addr_d3", 32'(rom_if.rom_addr), 32'hF);
    step(1);
    chk("data_F", 32'(rom_if.rom_data), 32'h0E);
    step(1);
    chk_slot("rom_d3", 4'b0111, 8'h8E);

    // Blank and decimal point
    hex_in   = 16'h3210;
    blank_in = 4'b0100;
    dp_in    = 4'b0001;
    reset_dut();
    step(8);
    chk_slot("bd_d1", 4'b1101, 8'hF9);
    step(8);
    chk_slot("bd_d2", 4'b1111, 8'hA4);
    step(8);
    chk_slot("bd_d3", 4'b0111, 8'hB0);
    step(8);
    chk_slot("bd_d0", 4'b1110, 8'h40);

    // Mid-slot hex change: digit 1 already fetched, new value shows next refresh
    step(6);
    hex_in = 16'h3280;
    step(2);
    chk_slot("mid_old", 4'b1101, 8'hF9);
    step(24);
    chk_slot("mid_d0", 4'b1110, 8'h40);
    step(8);
    chk_slot("mid_new", 4'b1101, 8'h80);

    // Async reset mid-slot, no clock edge
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_n), 32'h0000000F);
    chk("arst_sseg", 32'(sseg_n), 32'h000000FF);
    chk("arst_addr", 32'(rom_if.rom_addr), 32'h0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(8);
    chk_slot("arst_resume", 4'b1101, 8'h80);

    // Leading zeros
    hex_in   = 16'h0050;
    blank_in = 4'h0;
    dp_in    = 4'h0;
    reset_dut();
    step(8);
    chk_slot("lz_d1", 4'b1101, 8'h92);
`ifdef DISP_LZ_BLANK_EN
    step(8);
    chk("lz_d2", 32'(an_n), 32'hF);
    step(8);
    chk("lz_d3", 32'(an_n), 32'hF);
    step(8);
    chk_slot("lz_d0", 4'b1110, 8'hC0);
    hex_in = 16'h0000;
    step(8);
    chk("lz0_d1", 32'(an_n), 32'hF);
    step(8);
    chk("lz0_d2", 32'(an_n), 32'hF);
    step(8);
    chk("lz0_d3", 32'(an_n), 32'hF);
    step(8);
    chk_slot("lz0_d0", 4'b1110, 8'hC0);
`else
    step(8);
    chk_slot("nolz_d2", 4'b1011, 8'hC0);
    step(8);
    chk_slot("nolz_d3", 4'b0111, 8'hC0);
    step(8);
    chk_slot("nolz_d0", 4'b1110, 8'hC0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
